// File: rtl/core_pkg.sv
// Shared core constants: data-memory geometry and halfword lane-mask encodings.
package core_pkg;

  localparam int DM_ADDR_W = 6;
  localparam int WORD_W    = 32;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

endpackage

// File: rtl/data_memory.sv
// MEM-stage data memory: word RAM with a halfword-masked synchronous write port,
// two independent combinational read ports, and an asynchronous clear on reset.
module data_memory
  import core_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] disp_data
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LANE_W = DATA_W / 2;

  // Each halfword lane is its own array so that both lanes can be written
  // from separate processes without sharing a storage variable.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [LANE_W-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          lane_mem[i] <= '0;
        end
      end else if (we && sel[l]) begin
        lane_mem[addr] <= wdata[l*LANE_W +: LANE_W];
      end
    end

    assign rdata[l*LANE_W +: LANE_W]     = lane_mem[addr];
    assign disp_data[l*LANE_W +: LANE_W] = lane_mem[disp_addr];
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared against a word-array model updated with lane-mask arithmetic.
module tb_data_memory;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  addr = '0;
  logic [5:0]  disp_addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [1:0]  sel = SEL_NONE;
  logic [31:0] rdata;
  logic [31:0] disp_data;

  logic [31:0] model [64];
  int checks = 0;
  int passed = 0;

  data_memory #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .disp_addr(disp_addr),
    .wdata(wdata), .we(we), .sel(sel), .rdata(rdata), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merged(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [1:0] s);
    logic [31:0] mask;
    mask = {{16{s[1]}}, {16{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // Drive one store cycle at the falling edge, then return 1ns after the rising edge.
  task automatic cycle(input logic [5:0] a, input logic [31:0] d, input logic w, input logic [1:0] s);
    @(negedge clk);
    addr = a; wdata = d; we = w; sel = s;
    @(posedge clk);
    #1;
    if (w && !rst) model[a] = merged(model[a], d, s);
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_initial rdata got=%h exp=%h", rdata, 32'h0);
    else passed++;
    @(negedge clk); rst = 1'b0;
    cycle(6'd5, 32'h1234_5678, 1'b1, SEL_WORD);
    addr = 6'd5; we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h1234_5678) $display("FAIL reset_preload got=%h exp=%h", rdata, 32'h1234_5678);
    else passed++;
    @(negedge clk); #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_async_addr5 got=%h exp=%h", rdata, 32'h0);
    else passed++;
    for (int i = 0; i < 64; i++) begin
      disp_addr = 6'(i);
      #1;
      exp = model[i];
      checks++;
      if (disp_data !== exp) $display("FAIL reset_sweep[%0d] got=%h exp=%h", i, disp_data, exp);
      else passed++;
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word_write();
    cycle(6'd3, 32'hDEAD_BEEF, 1'b1, SEL_WORD);
    disp_addr = 6'd3;
    #1;
    checks++;
    if (rdata !== 32'hDEAD_BEEF) $display("FAIL word_rdata got=%h exp=%h", rdata, 32'hDEAD_BEEF);
    else passed++;
    checks++;
    if (disp_data !== 32'hDEAD_BEEF) $display("FAIL word_disp got=%h exp=%h", disp_data, 32'hDEAD_BEEF);
    else passed++;
  endtask

  task automatic test_lanes();
    cycle(6'd3, 32'h0000_1111, 1'b1, SEL_LO);
    checks++;
    if (rdata !== 32'hDEAD_1111) $display("FAIL lane_lo got=%h exp=%h", rdata, 32'hDEAD_1111);
    else passed++;
    cycle(6'd3, 32'h2222_0000, 1'b1, SEL_HI);
    checks++;
    if (rdata !== 32'h2222_1111) $display("FAIL lane_hi got=%h exp=%h", rdata, 32'h2222_1111);
    else passed++;
    cycle(6'd3, 32'h5555_AAAA, 1'b1, SEL_NONE);
    checks++;
    if (rdata !== 32'h2222_1111) $display("FAIL lane_none got=%h exp=%h", rdata, 32'h2222_1111);
    else passed++;
  endtask

  task automatic test_we_low();
    for (int i = 0; i < 3; i++) begin
      cycle(6'd3, 32'hFFFF_FFFF, 1'b0, SEL_WORD);
      checks++;
      if (rdata !== 32'h2222_1111) $display("FAIL we_low[%0d] got=%h exp=%h", i, rdata, 32'h2222_1111);
      else passed++;
    end
  endtask

  task automatic test_dual_port();
    logic [31:0] exp;
    @(negedge clk);
    addr = 6'd63; disp_addr = 6'd63; wdata = 32'hA5A5_A5A5; we = 1'b1; sel = SEL_WORD;
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL rdw_before_rdata got=%h exp=%h", rdata, 32'h0);
    else passed++;
    checks++;
    if (disp_data !== 32'h0) $display("FAIL rdw_before_disp got=%h exp=%h", disp_data, 32'h0);
    else passed++;
    @(posedge clk); #1;
    model[63] = 32'hA5A5_A5A5;
    checks++;
    if (rdata !== 32'hA5A5_A5A5) $display("FAIL rdw_after_rdata got=%h exp=%h", rdata, 32'hA5A5_A5A5);
    else passed++;
    checks++;
    if (disp_data !== 32'hA5A5_A5A5) $display("FAIL rdw_after_disp got=%h exp=%h", disp_data, 32'hA5A5_A5A5);
    else passed++;
    we = 1'b0;
    for (int i = 0; i < 63; i++) begin
      disp_addr = 6'(i);
      #1;
      exp = model[i];
      checks++;
      if (disp_data !== exp || rdata !== 32'hA5A5_A5A5)
        $display("FAIL dual_sweep[%0d] disp got=%h exp=%h rdata got=%h exp=%h",
                 i, disp_data, exp, rdata, 32'hA5A5_A5A5);
      else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) cycle(6'd10, $urandom, 1'b1, SEL_WORD);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL midrst_assert got=%h exp=%h", rdata, 32'h0);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      cycle(6'd10, $urandom | 32'h1, 1'b1, SEL_WORD);
      checks++;
      if (rdata !== 32'h0) $display("FAIL midrst_hold[%0d] got=%h exp=%h", i, rdata, 32'h0);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    d = $urandom | 32'h1;
    wdata = d;
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL midrst_release got=%h exp=%h", rdata, 32'h0);
    else passed++;
    @(posedge clk); #1;
    model[10] = d;
    checks++;
    if (rdata !== d) $display("FAIL midrst_first_write got=%h exp=%h", rdata, d);
    else passed++;
  endtask

  task automatic test_random();
    logic [5:0]  a, da;
    logic [31:0] d, exp_r, exp_d;
    logic [1:0]  s;
    logic        w;
    for (int n = 0; n < 300; n++) begin
      a = 6'($urandom_range(0, 63)); da = 6'($urandom_range(0, 63));
      d = $urandom; s = 2'($urandom_range(0, 3)); w = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      addr = a; disp_addr = da; wdata = d; we = w; sel = s;
      #1;
      exp_r = model[a]; exp_d = model[da];
      checks++;
      if (rdata !== exp_r || disp_data !== exp_d)
        $display("FAIL rand_pre[%0d] rdata got=%h exp=%h disp got=%h exp=%h",
                 n, rdata, exp_r, disp_data, exp_d);
      else passed++;
      @(posedge clk); #1;
      if (w) model[a] = merged(model[a], d, s);
      exp_r = model[a]; exp_d = model[da];
      checks++;
      if (rdata !== exp_r || disp_data !== exp_d)
        $display("FAIL rand_post[%0d] rdata got=%h exp=%h disp got=%h exp=%h",
                 n, rdata, exp_r, disp_data, exp_d);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_lanes();
    test_we_low();
    test_dual_port();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
